// File: rtl/sumres_serie.sv
// rtl/sumres_serie.sv - bit-serial N-bit adder/subtractor with start/busy/done handshake
//
// Purpose:
//   Adds or subtracts two N-bit two's-complement operands one bit per clock,
//   LSB first. Subtraction is A + ~B + 1: operand B is conditionally
//   one's-complemented and the carry flop is preloaded with op.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   nreset   in   1  synchronous active-low reset
//   Ent_A    in   N  operand A, sampled when a start is accepted
//   Ent_B    in   N  operand B, sampled when a start is accepted
//   op       in   1  0 = A+B, 1 = A-B, sampled when a start is accepted
//   inicio   in   1  start request, honoured only when idle
//   Sal      out  N  registered result
//   Cout     out  1  registered carry out of the MSB (1 = no borrow on subtract)
//   V        out  1  registered two's-complement overflow
//   ocupado  out  1  busy while bits are being processed
//   fin      out  1  one-cycle pulse when Sal/Cout/V are updated

module sumres_serie #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] Ent_A,
  input  logic [N-1:0] Ent_B,
  input  logic         op,
  input  logic         inicio,
  output logic [N-1:0] Sal,
  output logic         Cout,
  output logic         V,
  output logic         ocupado,
  output logic         fin
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(N - 2);

  typedef enum logic {
    REPOSO = 1'b0,
    SUMA   = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // control strobes from the output decoder
  logic load_en;
  logic shift_en;
  logic last_bit;

  // serial datapath
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_s;
  logic          c;
  logic          c_n1;
  logic [CW-1:0] cnt;

  logic s_bit;
  logic c_nx;

  // one full-adder slice working on the current LSBs
  assign s_bit = r_a[0] ^ r_b[0] ^ c;
  assign c_nx  = (r_a[0] & r_b[0]) | (r_a[0] & c) | (r_b[0] & c);

  // state register
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= REPOSO;
    end else begin
      state <= state_nx;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      REPOSO: if (inicio) state_nx = SUMA;
      SUMA:   if (cnt == CNT_LAST) state_nx = REPOSO;
      default: state_nx = REPOSO;
    endcase
  end

  // output / control decoder
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    last_bit = 1'b0;
    case (state)
      REPOSO: load_en = inicio;
      SUMA: begin
        shift_en = 1'b1;
        last_bit = (cnt == CNT_LAST);
      end
      default: ;
    endcase
  end

  // operand shift registers, carry flop and bit counter
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_s  <= '0;
      c    <= 1'b0;
      c_n1 <= 1'b0;
      cnt  <= '0;
    end else if (load_en) begin
      r_a  <= Ent_A;
      r_b  <= Ent_B ^ {N{op}};
      c    <= op;
      c_n1 <= 1'b0;
      r_s  <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      r_a <= {1'b0, r_a[N-1:1]};
      r_b <= {1'b0, r_b[N-1:1]};
      r_s <= {s_bit, r_s[N-1:1]};
      c   <= c_nx;
      cnt <= cnt + CW'(1);
      // carry generated by bit N-2 is the carry into the MSB; keep it for V
      if (cnt == CNT_PRE) c_n1 <= c_nx;
    end
  end

  // result registers; they only move on completion so they hold across starts
  always_ff @(posedge clk) begin
    if (!nreset) begin
      Sal  <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
      fin  <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (last_bit) begin
        Sal  <= {s_bit, r_s[N-1:1]};
        Cout <= c_nx;
        V    <= c_n1 ^ c_nx;
        fin  <= 1'b1;
      end
    end
  end

  assign ocupado = (state == SUMA);

endmodule

// File: tb/tb_sumres_serie.sv
// tb/tb_sumres_serie.sv - directed self-checking bench for sumres_serie (N=4)

module tb_sumres_serie;

  localparam int N = 4;

  logic         clk;
  logic         nreset;
  logic [N-1:0] Ent_A;
  logic [N-1:0] Ent_B;
  logic         op;
  logic         inicio;
  logic [N-1:0] Sal;
  logic         Cout;
  logic         V;
  logic         ocupado;
  logic         fin;

  int tests = 0;
  int fails = 0;

  sumres_serie #(.N(N)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .Ent_A   (Ent_A),
    .Ent_B   (Ent_B),
    .op      (op),
    .inicio  (inicio),
    .Sal     (Sal),
    .Cout    (Cout),
    .V       (V),
    .ocupado (ocupado),
    .fin     (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".Sal"}, 32'(Sal), 32'd0);
    check({tag, ".Cout"}, 32'(Cout), 32'd0);
    check({tag, ".V"}, 32'(V), 32'd0);
    check({tag, ".ocupado"}, 32'(ocupado), 32'd0);
    check({tag, ".fin"}, 32'(fin), 32'd0);
  endtask

  // waits for fin, bounded; returns the number of edges it took
  task automatic wait_fin(input bit disturb, output int cyc);
    cyc = 0;
    while (!fin && cyc < 12) begin
      if (disturb) begin
        inicio = 1'b1;
        Ent_A  = 4'($urandom);
        Ent_B  = 4'($urandom);
        op     = 1'($urandom);
      end
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic o, input logic [3:0] es, input logic ec,
                        input logic ev, input bit disturb);
    int cyc;
    Ent_A  = a;
    Ent_B  = b;
    op     = o;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    check({tag, ".busy"}, 32'(ocupado), 32'd1);
    wait_fin(disturb, cyc);
    inicio = 1'b0;
    check({tag, ".latency"}, 32'(cyc), 32'd4);
    check({tag, ".fin"}, 32'(fin), 32'd1);
    check({tag, ".Sal"}, 32'(Sal), 32'(es));
    check({tag, ".Cout"}, 32'(Cout), 32'(ec));
    check({tag, ".V"}, 32'(V), 32'(ev));
    check({tag, ".idle_at_fin"}, 32'(ocupado), 32'd0);
    tick();
    check({tag, ".fin_pulse"}, 32'(fin), 32'd0);
    check({tag, ".hold_Sal"}, 32'(Sal), 32'(es));
  endtask

  // back-to-back table: A, B, op, Sal, Cout, V
  logic [3:0] bb_a   [3] = '{4'd1, 4'd9, 4'd15};
  logic [3:0] bb_b   [3] = '{4'd2, 4'd3, 4'd15};
  logic       bb_op  [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] bb_s   [3] = '{4'd3, 4'd6, 4'd14};
  logic       bb_c   [3] = '{1'b0, 1'b1, 1'b1};
  logic       bb_v   [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    int cyc;
    nreset = 1'b0;
    Ent_A  = '0;
    Ent_B  = '0;
    op     = 1'b0;
    inicio = 1'b0;
    tick();
    tick();
    nreset = 1'b1;

    // reset state held through idle cycles
    for (int i = 0; i < 3; i++) begin
      check_idle_zero("reset_idle");
      tick();
    end

    run_op("add_3_4",   4'd3, 4'd4, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0);
    run_op("add_7_1",   4'd7, 4'd1, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
    run_op("sub_5_3",   4'd5, 4'd3, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0);
    run_op("sub_0_1",   4'd0, 4'd1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    run_op("sub_8_1",   4'd8, 4'd1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0);
    run_op("sub_0_0",   4'd0, 4'd0, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0);
    run_op("sub_9_0",   4'd9, 4'd0, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0);
    run_op("add_8_8",   4'd8, 4'd8, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0);
    // inicio pulses and operand churn while busy must not disturb the result
    run_op("busy_6_5",  4'd6, 4'd5, 1'b0, 4'd11, 1'b0, 1'b1, 1'b1);

    // back-to-back with inicio held high; next operands presented in the fin cycle
    inicio = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Ent_A = bb_a[k];
      Ent_B = bb_b[k];
      op    = bb_op[k];
      tick();
      check("b2b.busy", 32'(ocupado), 32'd1);
      Ent_A = ~bb_a[k];
      Ent_B = ~bb_b[k];
      op    = ~bb_op[k];
      wait_fin(1'b0, cyc);
      check("b2b.latency", 32'(cyc), 32'd4);
      check("b2b.Sal", 32'(Sal), 32'(bb_s[k]));
      check("b2b.Cout", 32'(Cout), 32'(bb_c[k]));
      check("b2b.V", 32'(V), 32'(bb_v[k]));
    end
    inicio = 1'b0;
    tick();
    check("b2b.stop", 32'(ocupado), 32'd0);

    // reset two cycles into an operation
    Ent_A  = 4'd7;
    Ent_B  = 4'd7;
    op     = 1'b0;
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick();
    tick();
    check("midrst.busy_before", 32'(ocupado), 32'd1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    check_idle_zero("midrst");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst.no_fin", 32'(fin), 32'd0);
    end
    run_op("after_rst_2_2", 4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
